gray_sync_decode: RTL and testbench

- Consumer stage for the gray_count pointer/counter.
- Resynchronises an N-bit gray code into the local clk domain and converts it to registered binary.
- Classifies each observed change as a legal +1 step, a wrap, or an error (multi-bit change or backward move).
- Used on the read side of FIFO/pointer crossings and for counter health monitoring.

---
 rtl/gray_pkg.sv | 36 +++
 rtl/gray_sync_decode_if.sv | 39 +++
 rtl/gray_sync_chain.sv | 27 ++
 rtl/gray_sync_decode.sv | 105 ++++++++++
 tb/tb_gray_sync_decode.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared gray-code helpers and default sizing for the gray_count / gray_sync_decode family.
// The helpers work on a fixed 32-bit word. Narrower codes are zero-extended on the way in
// and truncated on the way out; zero high bits do not change the low bits of either
// transform, so the result is correct for any N <= 32.
package gray_pkg;

  localparam int unsigned GRAY_DEFAULT_N    = 8;
  localparam int unsigned GRAY_SYNC_DEFAULT = 2;

  localparam int unsigned GrayMaxW = 32;
  typedef logic [GrayMaxW-1:0] gray_word_t;

  // bin[i] is the XOR of all gray bits at or above i.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GrayMaxW-1] = g[GrayMaxW-1];
    for (int i = GrayMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input gray_word_t w);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(GrayMaxW); i++) begin
      cnt += {31'b0, w[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync_decode_if.sv
// Bus bundle for gray_sync_decode: control inputs, the gray code and the decoded results.
// The err_cnt signal exists only when GRAY_SYNC_ERR_CNT_EN is defined.
interface gray_sync_decode_if
  import gray_pkg::*;
#(
  parameter int unsigned N = GRAY_DEFAULT_N
);

  logic         enable;
  logic [N-1:0] gray_in;
  logic         err_clr;
  logic [N-1:0] gray_sync;
  logic [N-1:0] bin_count;
  logic         step;
  logic         wrap;
  logic         err;
`ifdef GRAY_SYNC_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  // Side that drives the gray code and control (producer / test environment).
  modport master (
    output enable, gray_in, err_clr,
    input  gray_sync, bin_count, step, wrap, err
`ifdef GRAY_SYNC_ERR_CNT_EN
    , input err_cnt
`endif
  );

  // Decoder side.
  modport slave (
    input  enable, gray_in, err_clr,
    output gray_sync, bin_count, step, wrap, err
`ifdef GRAY_SYNC_ERR_CNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/gray_sync_chain.sv
// Plain multi-flop synchroniser for an N-bit gray code. Kept in its own module so the
// crossing flops can be constrained and identified separately. Every bit is synchronised
// independently; gray coding guarantees at most one bit is in flight per change.
module gray_sync_chain #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [SYNC_STAGES-1:0][N-1:0] stage_q;

  // Shift the input through the chain every cycle; stage 0 is the first capture flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decode.sv
// Consumer stage for a gray_count pointer: synchronises the gray code into this clock domain,
// converts it to registered binary and classifies each change as a legal +1 step, a wrap,
// or an error (multi-bit change or backward move). err is sticky until err_clr.
// Optional feature: define GRAY_SYNC_ERR_CNT_EN to add err_cnt, a saturating 8-bit count of
// illegal transitions. N must be in 2..32.
module gray_sync_decode
  import gray_pkg::*;
#(
  parameter int unsigned N           = GRAY_DEFAULT_N,
  parameter int unsigned SYNC_STAGES = GRAY_SYNC_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  gray_sync_decode_if.slave   bus
);

  logic [N-1:0] gray_sync;
  logic [N-1:0] gray_prev_q;
  logic [N-1:0] bin_count_q;
  logic [N-1:0] bin_next;
  logic         step_q, step_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic         err_set;
  int unsigned  diff_bits;

  gray_sync_chain #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (bus.gray_in),
    .q_o     (gray_sync)
  );

  // Decode the synchronised code and classify the change against the previous sample.
  always_comb begin
    bin_next  = N'(gray2bin(gray_word_t'(gray_sync)));
    diff_bits = popcount(gray_word_t'(gray_sync ^ gray_prev_q));
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    err_set   = 1'b0;
    if (bus.enable && (diff_bits != 0)) begin
      // A +1 binary advance always flips exactly one gray bit, so this covers d == 1 only.
      if ((diff_bits == 1) && (bin_next == bin_count_q + N'(1))) begin
        step_d = 1'b1;
        wrap_d = (bin_count_q == '1);
      end else begin
        err_set = 1'b1;
      end
    end
    // A new error outranks a same-cycle clear.
    err_d = err_set | (err_q & ~bus.err_clr);
  end

  // Decode register and result flags; bin_count tracks gray_sync even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_prev_q <= '0;
      bin_count_q <= '0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_sync;
      bin_count_q <= bin_next;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign bus.gray_sync = gray_sync;
  assign bus.bin_count = bin_count_q;
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

`ifdef GRAY_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error count; a clear coinciding with a new error leaves a count of one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr) begin
      err_cnt_d = {7'b0, err_set};
    end else if (err_set && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_gray_sync_decode.sv
// Self-checking bench for gray_sync_decode (N=8, SYNC_STAGES=2). A reference model built on
// a delay line of sampled gray codes and plain binary arithmetic predicts every output each
// cycle; directed steps add fixed expectations on top, followed by a randomized run.
module tb_gray_sync_decode;

  localparam int N    = 8;
  localparam int SS   = 2;
  localparam int MODV = 1 << N;

  logic clk = 1'b0;
  logic reset;
  logic en, clr;
  logic [N-1:0] gin;

  always #5 clk = ~clk;

  gray_sync_decode_if #(.N(N)) bus ();

  assign bus.enable  = en;
  assign bus.gray_in = gin;
  assign bus.err_clr = clr;

  gray_sync_decode #(
    .N           (N),
    .SYNC_STAGES (SS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int m_hist[SS+2];   // m_hist[0] = gray code sampled at the latest edge
  int m_step, m_wrap, m_err, m_cnt;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search: the binary value whose gray code matches.
  function automatic int from_gray(input int g);
    for (int v = 0; v < MODV; v++) begin
      if (to_gray(v) == g) return v;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SS + 2; i++) m_hist[i] = 0;
    m_step = 0;
    m_wrap = 0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    int nb, pb;
    bit ev;
    if (reset) begin
      model_clear();
      return;
    end
    for (int i = SS + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(gin);
    nb = from_gray(m_hist[SS]);
    pb = from_gray(m_hist[SS+1]);
    ev = 1'b0;
    m_step = 0;
    m_wrap = 0;
    if (en && nb != pb) begin
      if (nb == (pb + 1) % MODV) begin
        m_step = 1;
        m_wrap = (pb == MODV - 1) ? 1 : 0;
      end else begin
        ev = 1'b1;
      end
    end
    if (ev) m_err = 1;
    else if (clr) m_err = 0;
    if (clr) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < 255) m_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gray_sync"}, 32'(bus.gray_sync), m_hist[SS-1]);
    chk({tag, ".bin_count"}, 32'(bus.bin_count), from_gray(m_hist[SS]));
    chk({tag, ".step"}, 32'(bus.step), m_step);
    chk({tag, ".wrap"}, 32'(bus.wrap), m_wrap);
    chk({tag, ".err"}, 32'(bus.err), m_err);
`ifdef GRAY_SYNC_ERR_CNT_EN
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), m_cnt);
`endif
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Hold a gray code long enough for its change to reach bin_count (3 edges).
  task automatic apply(input int g, input string tag);
    gin = g[N-1:0];
    repeat (3) tick(tag);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all(tag);
    chk({tag, ".bin_zero"}, 32'(bus.bin_count), 0);
    tick(tag);
    reset = 1'b0;
  endtask

  initial begin
    int cur_b, r;
    reset = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    gin   = '0;
    model_clear();
    tick("reset");
    tick("reset");
    chk("reset_bin", 32'(bus.bin_count), 0);
    chk("reset_err", 32'(bus.err), 0);
    reset = 1'b0;
    en    = 1'b1;

    // Legal count 0..3.
    apply(8'h00, "seq0");
    apply(8'h01, "seq1");
    chk("seq1_bin", 32'(bus.bin_count), 1);
    chk("seq1_step", 32'(bus.step), 1);
    apply(8'h03, "seq2");
    chk("seq2_bin", 32'(bus.bin_count), 2);
    apply(8'h02, "seq3");
    chk("seq3_bin", 32'(bus.bin_count), 3);
    chk("seq3_step", 32'(bus.step), 1);
    chk("seq3_err", 32'(bus.err), 0);

    // Wrap 255 -> 0.
    en = 1'b0;
    apply(8'h80, "to255");
    en = 1'b1;
    apply(8'h00, "wrap");
    chk("wrap_bin", 32'(bus.bin_count), 0);
    chk("wrap_step", 32'(bus.step), 1);
    chk("wrap_wrap", 32'(bus.wrap), 1);
    tick("wrap_after");
    chk("wrap_pulse_end", 32'(bus.wrap), 0);

    // Multi-bit jump 1 -> 5 is sticky.
    apply(8'h01, "jmp_pre");
    apply(8'h07, "jmp");
    chk("jmp_bin", 32'(bus.bin_count), 5);
    chk("jmp_step", 32'(bus.step), 0);
    chk("jmp_err", 32'(bus.err), 1);
    repeat (10) tick("jmp_hold");
    chk("jmp_sticky", 32'(bus.err), 1);

    // err_clr alone clears.
    clr = 1'b1;
    tick("clr0");
    clr = 1'b0;
    chk("clr0_err", 32'(bus.err), 0);

    // Backward single-bit move 2 -> 1.
    en = 1'b0;
    apply(8'h03, "back_pre");
    en = 1'b1;
    apply(8'h01, "back");
    chk("back_err", 32'(bus.err), 1);
    chk("back_step", 32'(bus.step), 0);
    clr = 1'b1;
    tick("clr1");
    clr = 1'b0;
    chk("clr1_err", 32'(bus.err), 0);

    // err_clr coinciding with a new error: error wins.
    en = 1'b0;
    apply(8'h00, "race_pre");
    en  = 1'b1;
    gin = 8'h05;
    tick("race");
    tick("race");
    clr = 1'b1;
    tick("race_edge");
    clr = 1'b0;
    chk("race_err", 32'(bus.err), 1);
    clr = 1'b1;
    tick("clr2");
    clr = 1'b0;

    // Disabled tracking, then re-enable without false error.
    en = 1'b0;
    apply(8'h00, "dis0");
    apply(8'h0F, "dis1");
    chk("dis_bin", 32'(bus.bin_count), 10);
    chk("dis_step", 32'(bus.step), 0);
    chk("dis_err", 32'(bus.err), 0);
    en = 1'b1;
    apply(8'h0E, "reen");
    chk("reen_bin", 32'(bus.bin_count), 11);
    chk("reen_step", 32'(bus.step), 1);
    chk("reen_err", 32'(bus.err), 0);

    // Reset mid-sequence at bin_count 3.
    en = 1'b0;
    apply(8'h02, "pre_rst");
    en = 1'b1;
    chk("pre_rst_bin", 32'(bus.bin_count), 3);
    do_reset("midrst");
    tick("post_rst");
    chk("post_rst_step", 32'(bus.step), 0);
    repeat (3) tick("post_rst");

`ifdef GRAY_SYNC_ERR_CNT_EN
    // Saturation of the error count.
    for (int i = 0; i < 300; i++) begin
      gin = (i % 2 == 0) ? 8'h00 : 8'h05;
      tick("sat");
    end
    repeat (3) tick("sat_flush");
    chk("sat_cnt", 32'(bus.err_cnt), 255);
    clr = 1'b1;
    tick("sat_clr");
    clr = 1'b0;
    chk("sat_clr_cnt", 32'(bus.err_cnt), 0);
`endif

    // Randomized run: mostly legal increments, some holds and arbitrary jumps.
    cur_b = from_gray(int'(gin));
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) cur_b = (cur_b + 1) % MODV;
      else if (r >= 80) cur_b = int'($urandom_range(0, MODV - 1));
      gin = 8'(to_gray(cur_b));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      else tick("rnd");
    end
    clr = 1'b0;
    repeat (4) tick("rnd_flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
